perceptron_vector_loader: RTL and testbench

- Upstream feeder for the perceptron stage.
- Accepts input-vector elements serially over a valid/ready stream and assembles them into the packed N-element x vector.
- Presents the vector with a valid/ready handshake.
- Generates a y_valid strobe aligned to the perceptron's fixed output latency, so downstream logic knows when y carries a real result.

---
 rtl/kiwi_npu_pkg.sv | 13 +
 rtl/valid_delay_line.sv | 29 ++
 rtl/perceptron_vector_loader.sv | 158 +++++++++++++++
 tb/tb_perceptron_vector_loader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kiwi_npu_pkg.sv
// Shared types and default vector geometry for the kiwi NPU perceptron path.
// The loader and the perceptron both take N and DATA_WIDTH from here so they stay in step.
package kiwi_npu_pkg;

    localparam int KIWI_N          = 4;
    localparam int KIWI_DATA_WIDTH = 8;

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        ISSUE = 1'b1
    } loader_state_e;

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-latency valid pipeline: o_valid repeats i_valid DEPTH cycles later, never stalls.
// Synchronous active-low reset clears every stage.
module valid_delay_line
    import kiwi_npu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_valid,
    output logic o_valid
);

    logic [DEPTH-1:0] r_shift;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_shift <= '0;
        end else begin
            r_shift[0] <= i_valid;
            for (int i = 1; i < DEPTH; i++) begin
                r_shift[i] <= r_shift[i-1];
            end
        end
    end

    assign o_valid = r_shift[DEPTH-1];

endmodule

// File: rtl/perceptron_vector_loader.sv
// Serial-to-packed x vector loader for the perceptron; m_valid the cycle after the closing element, y_valid PIPE_LAT after consume.
// Short frames are zero-padded; s_ready drops in ISSUE unless LOADER_PINGPONG_EN adds a back buffer.
module perceptron_vector_loader
    import kiwi_npu_pkg::*;
#(
    parameter int N          = KIWI_N,
    parameter int DATA_WIDTH = KIWI_DATA_WIDTH,
    parameter int PIPE_LAT   = 2,
    parameter int CNT_WIDTH  = $clog2(N) + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic signed [DATA_WIDTH-1:0] s_data,
    input  logic                         s_last,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [N*DATA_WIDTH-1:0]      x,
    output logic                         short_frame,
    output logic                         y_valid
);

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(N - 1);

    loader_state_e               r_state;
    loader_state_e               w_state_nxt;
    logic [CNT_WIDTH-1:0]        r_count;
    logic [N*DATA_WIDTH-1:0]     r_x;
    logic                        r_short;
    logic                        r_hs;
    logic [N*DATA_WIDTH-1:0]     w_base;
    logic [N*DATA_WIDTH-1:0]     w_frame_nxt;
    logic                        w_s_ready;
    logic                        w_m_valid;
    logic                        w_accept;
    logic                        w_last_slot;
    logic                        w_done;
    logic                        w_short_nxt;
    logic                        w_hs;

`ifdef LOADER_PINGPONG_EN
    logic [N*DATA_WIDTH-1:0]     r_fill;
    logic                        r_fill_short;
    logic                        r_fill_full;

    // Elements accumulate in the back buffer; the front only ever holds complete vectors.
    assign w_base    = r_fill;
    assign w_s_ready = !r_fill_full;
`else
    assign w_base    = r_x;
    assign w_s_ready = (r_state == FILL);
`endif

    assign w_m_valid   = (r_state == ISSUE);
    assign w_accept    = s_valid && w_s_ready;
    assign w_last_slot = (r_count == LAST_IDX);
    assign w_done      = w_accept && (w_last_slot || s_last);
    assign w_short_nxt = !w_last_slot;
    assign w_hs        = w_m_valid && m_ready;

    // Write the new element and, on an early s_last, clear every slot above it.
    always_comb begin
        w_frame_nxt = w_base;
        for (int i = 0; i < N; i++) begin
            if (CNT_WIDTH'(i) == r_count) begin
                w_frame_nxt[i*DATA_WIDTH +: DATA_WIDTH] = s_data;
            end else if ((CNT_WIDTH'(i) > r_count) && s_last) begin
                w_frame_nxt[i*DATA_WIDTH +: DATA_WIDTH] = '0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FILL: begin
                if (w_done) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
`ifdef LOADER_PINGPONG_EN
                if (m_ready && !r_fill_full && !w_done) begin
                    w_state_nxt = FILL;
                end
`else
                if (m_ready) begin
                    w_state_nxt = FILL;
                end
`endif
            end
            default: w_state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= FILL;
            r_count <= '0;
            r_x     <= '0;
            r_short <= 1'b0;
            r_hs    <= 1'b0;
`ifdef LOADER_PINGPONG_EN
            r_fill       <= '0;
            r_fill_short <= 1'b0;
            r_fill_full  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_hs    <= w_hs;
            if (w_accept) begin
                r_count <= w_done ? '0 : r_count + 1'b1;
            end
`ifdef LOADER_PINGPONG_EN
            if (w_accept) begin
                r_fill <= w_frame_nxt;
            end
            if (w_done) begin
                if ((r_state == FILL) || m_ready) begin
                    r_x     <= w_frame_nxt;
                    r_short <= w_short_nxt;
                end else begin
                    r_fill_short <= w_short_nxt;
                    r_fill_full  <= 1'b1;
                end
            end else if (w_hs && r_fill_full) begin
                r_x         <= r_fill;
                r_short     <= r_fill_short;
                r_fill_full <= 1'b0;
            end
`else
            if (w_accept) begin
                r_x <= w_frame_nxt;
            end
            if (w_done) begin
                r_short <= w_short_nxt;
            end
`endif
        end
    end

    // r_hs marks the edge x was taken; PIPE_LAT more stages line y_valid up with y.
    valid_delay_line #(
        .DEPTH (PIPE_LAT)
    ) u_y_valid_dly (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (r_hs),
        .o_valid (y_valid)
    );

    assign s_ready     = w_s_ready;
    assign m_valid     = w_m_valid;
    assign x           = r_x;
    assign short_frame = r_short;

endmodule

// File: tb/tb_perceptron_vector_loader.sv
// Directed and randomised bench for perceptron_vector_loader with a vector scoreboard and y_valid timing model.
module tb_perceptron_vector_loader;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int PL = 2;

    typedef struct packed {
        logic [N*DW-1:0] x;
        logic            sh;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            s_valid = 1'b0;
    logic            s_last = 1'b0;
    logic [DW-1:0]   s_data = '0;
    logic            m_ready = 1'b0;
    logic            s_ready;
    logic            m_valid;
    logic [N*DW-1:0] x;
    logic            short_frame;
    logic            y_valid;

    int   checks = 0;
    int   errors = 0;
    int   stall_cnt = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [DW-1:0] mdl [N];
    int   mdl_cnt = 0;
    bit   rand_mode = 1'b0;
    bit   mready_fixed = 1'b1;
    bit   mon_en = 1'b0;
    logic [2:0] hist = 3'b000;

    perceptron_vector_loader #(
        .N          (N),
        .DATA_WIDTH (DW),
        .PIPE_LAT   (PL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .x           (x),
        .short_frame (short_frame),
        .y_valid     (y_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_accept(input logic [DW-1:0] d, input bit last);
        exp_t e;
        mdl[mdl_cnt] = d;
        mdl_cnt++;
        if (mdl_cnt == N || last) begin
            e.x = '0;
            for (int i = 0; i < mdl_cnt; i++) e.x[i*DW +: DW] = mdl[i];
            e.sh = (mdl_cnt < N);
            exp_q.push_back(e);
            mdl_cnt = 0;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_elem(input logic [DW-1:0] d, input bit last);
        bit ok = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        for (int w = 0; w < 200 && !ok; w++) begin
            @(negedge clk);
            if (s_ready === 1'b1) ok = 1'b1;
            else stall_cnt++;
        end
        if (ok) begin
            @(posedge clk);
            #1;
            model_accept(d, last);
        end else begin
            checks++;
            errors++;
            $error("FAIL accept_timeout: observed s_ready low for 200 cycles expected an accept");
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        m_ready = rand_mode ? ($urandom_range(0, 3) != 0) : mready_fixed;
    end

    // hist[2] holds the handshake seen three negedges ago, i.e. consumed PL edges before this cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("y_valid_timing", 64'(y_valid), 64'(hist[2]));
            if (rst_n && m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_vector: observed %0h expected none", x);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("vec_x", 64'(x), 64'(mon_e.x));
                    chk("vec_short", 64'(short_frame), 64'(mon_e.sh));
                end
            end
            hist = rst_n ? {hist[1:0], m_valid && m_ready} : 3'b000;
        end
    end

    initial begin
        logic [DW-1:0] rd;
        int len;

        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_x", 64'(x), 64'd0);
        chk("rst_short", 64'(short_frame), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd1);
        chk("rst_y_valid", 64'(y_valid), 64'd0);

        // Full frame 3,-2,5,1 consumed immediately
        send_elem(8'h03, 1'b0);
        send_elem(8'hFE, 1'b0);
        send_elem(8'h05, 1'b0);
        send_elem(8'h01, 1'b0);
        chk("ff_m_valid", 64'(m_valid), 64'd1);
        chk("ff_x", 64'(x), 64'h0105FE03);
        chk("ff_short", 64'(short_frame), 64'd0);
        @(posedge clk); #1;
        chk("ff_m_valid_after_hs", 64'(m_valid), 64'd0);
        chk("ff_y_k1", 64'(y_valid), 64'd0);
        @(posedge clk); #1;
        chk("ff_y_k2", 64'(y_valid), 64'd0);
        @(posedge clk); #1;
        chk("ff_y_k3", 64'(y_valid), 64'd1);
        @(posedge clk); #1;
        chk("ff_y_k4", 64'(y_valid), 64'd0);

        // Short frame then full frame
        send_elem(8'h07, 1'b0);
        send_elem(8'h09, 1'b1);
        chk("sf_m_valid", 64'(m_valid), 64'd1);
        chk("sf_x", 64'(x), 64'h00000907);
        chk("sf_short", 64'(short_frame), 64'd1);
        for (int i = 1; i <= N; i++) send_elem(DW'(i), 1'b0);
        chk("sf_next_x", 64'(x), 64'h04030201);
        chk("sf_next_short", 64'(short_frame), 64'd0);
        repeat (3) @(posedge clk);
        #1;

        // Backpressure for 5 cycles in ISSUE
        mready_fixed = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send_elem(8'h0A, 1'b0);
        send_elem(8'h14, 1'b0);
        send_elem(8'h1E, 1'b0);
        send_elem(8'h28, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_m_valid", 64'(m_valid), 64'd1);
            chk("bp_x", 64'(x), 64'h281E140A);
`ifdef LOADER_PINGPONG_EN
            chk("bp_s_ready", 64'(s_ready), 64'd1);
`else
            chk("bp_s_ready", 64'(s_ready), 64'd0);
`endif
            chk("bp_y_valid", 64'(y_valid), 64'd0);
        end
        mready_fixed = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_released", 64'(m_valid), 64'd0);

        // Reset in the middle of a frame
        send_elem(8'h11, 1'b0);
        send_elem(8'h22, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        mdl_cnt = 0;
        chk("rm_x", 64'(x), 64'd0);
        chk("rm_m_valid", 64'(m_valid), 64'd0);
        chk("rm_s_ready", 64'(s_ready), 64'd1);
        chk("rm_short", 64'(short_frame), 64'd0);
        send_elem(8'h44, 1'b0);
        send_elem(8'h55, 1'b0);
        send_elem(8'h66, 1'b0);
        send_elem(8'h77, 1'b0);
        chk("rm_clean_x", 64'(x), 64'h77665544);
        chk("rm_clean_short", 64'(short_frame), 64'd0);
        repeat (4) @(posedge clk);
        #1;

`ifdef LOADER_PINGPONG_EN
        // Back-to-back vectors with a continuous stream
        stall_cnt = 0;
        for (int v = 1; v <= 3 * N; v++) send_elem(DW'(v), 1'b0);
        chk("pp_no_stall", 64'(stall_cnt), 64'd0);
        repeat (6) @(posedge clk);
        #1;
`endif

        // Random valid gaps, random m_ready, frame lengths 1..6
        rand_mode = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            len = $urandom_range(1, 6);
            for (int e = 0; e < len; e++) begin
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
                rd = DW'($urandom_range(0, 255));
                send_elem(rd, e == len - 1);
            end
        end
        rand_mode = 1'b0;
        for (int w = 0; w < 200 && exp_q.size() > 0; w++) @(posedge clk);
        repeat (6) @(posedge clk);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("final_m_valid", 64'(m_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
